// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC router types, defaults and one-hot pointer helper
package noc_pkg;

    localparam int FLIT_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_DEPTH  = 8;

    typedef enum logic [2:0] {
        PORT_N,
        PORT_E,
        PORT_W,
        PORT_S,
        PORT_L
    } port_e;

    // Crossbar select encodings, one bit per input port, shared with the arbiter
    localparam logic [4:0] XBAR_SEL_N = 5'b00001;
    localparam logic [4:0] XBAR_SEL_E = 5'b00010;
    localparam logic [4:0] XBAR_SEL_W = 5'b00100;
    localparam logic [4:0] XBAR_SEL_S = 5'b01000;
    localparam logic [4:0] XBAR_SEL_L = 5'b10000;

    // Rotate a one-hot pointer left within its low 'depth' bits
    function automatic logic [MAX_DEPTH-1:0] rotl_onehot(input logic [MAX_DEPTH-1:0] ptr,
                                                          input int depth);
        logic [MAX_DEPTH-1:0] r;
        int j;
        r = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (i < depth) begin
                j = (i + 1) % depth;
                r[j[2:0]] = ptr[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cts_handshake.sv
// rtl/cts_handshake.sv - RTS/CTS receiver: CTS register and write enable generation
module cts_handshake (
    input  logic clk,
    input  logic rst,
    input  logic drts,
    input  logic full,
    output logic cts,
    output logic write_en
);

    logic cts_ff;

    // cts_ff blocks a second write while upstream is still dropping RTS
    always_comb begin
        write_en = drts & ~cts_ff & ~full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cts_ff <= 1'b0;
        end else begin
            cts_ff <= write_en;
        end
    end

    assign cts = cts_ff;

endmodule

// File: rtl/router_input_fifo.sv
// rtl/router_input_fifo.sv - NoC router input buffer; ROUTER_FIFO_OCCUPANCY_EN adds occupancy/underflow_err
module router_input_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         RX,
    input  logic                          DRTS,
    output logic                          CTS,
    input  logic                          read_en_N,
    input  logic                          read_en_E,
    input  logic                          read_en_W,
    input  logic                          read_en_S,
    input  logic                          read_en_L,
    output logic [DATA_WIDTH-1:0]         Data_out,
    output logic                          empty,
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic                          underflow_err,
`endif
    output logic                          full
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      read_ptr;
    logic [DEPTH-1:0]      write_ptr;
    logic [CW-1:0]         count;
    logic [4:0]            read_vec;
    logic                  write_en;
    logic                  pop;

    cts_handshake u_cts (
        .clk      (clk),
        .rst      (rst),
        .drts     (DRTS),
        .full     (full),
        .cts      (CTS),
        .write_en (write_en)
    );

    always_comb begin
        read_vec         = '0;
        read_vec[PORT_N] = read_en_N;
        read_vec[PORT_E] = read_en_E;
        read_vec[PORT_W] = read_en_W;
        read_vec[PORT_S] = read_en_S;
        read_vec[PORT_L] = read_en_L;
    end

    // Several grants at once collapse into a single pop
    assign pop   = (|read_vec) & ~empty;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_comb begin
        Data_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read_ptr[i]) begin
                Data_out = Data_out | mem[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write_en && write_ptr[i]) begin
                mem[i] <= RX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_ptr  <= DEPTH'(1);
            write_ptr <= DEPTH'(1);
            count     <= '0;
        end else begin
            if (write_en) begin
                write_ptr <= DEPTH'(rotl_onehot(MAX_DEPTH'(write_ptr), DEPTH));
            end
            if (pop) begin
                read_ptr <= DEPTH'(rotl_onehot(MAX_DEPTH'(read_ptr), DEPTH));
            end
            if (write_en && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !write_en) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef ROUTER_FIFO_OCCUPANCY_EN
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_err <= 1'b0;
        end else if (((|read_vec) && empty) || ($countones(read_vec) > 1)) begin
            underflow_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/router_input_fifo.md
Name: router_input_fifo

Overview:
- Input-port receive buffer of a mesh NoC router; downstream end of the RTS/DCTS link driven by an output-port arbiter of the neighbouring router.
- Accepts one flit per RTS/CTS handshake into a small FIFO.
- Presents the head flit to the local crossbar.
- Pops on a grant from whichever of this router's five output arbiters selected this input port.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, number of flit entries; 2..8, one-hot pointers of DEPTH bits.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- RX  input  DATA_WIDTH  incoming flit, valid while DRTS=1
- DRTS  input  1  upstream request-to-send (the upstream arbiter's RTS)
- CTS  output  1  clear-to-send pulse back to upstream (the upstream arbiter's DCTS)
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  input  1 each  pop requests; each is the Grant of that output arbiter for this input
- Data_out  output  DATA_WIDTH  head flit, meaningful only when empty=0
- empty  output  1  FIFO holds no flits
- full  output  1  FIFO holds DEPTH flits

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - CTS=0, empty=1, full=0.
  - read_ptr=write_ptr=one-hot bit0; count=0.
  - Memory contents not reset; Data_out is don't-care while empty.
- Receive handshake (CTS_FF register drives CTS):
  - CTS_FF_in=1 iff DRTS=1 and CTS_FF=0 and full=0; otherwise 0.
  - write_en = CTS_FF_in. On that edge, RX is stored at mem[write_ptr], write_ptr rotates left by one, and CTS_FF becomes 1.
  - CTS is therefore a one-cycle pulse, at most once every two cycles. This matches the upstream arbiter dropping RTS when RTS&&DCTS.
  - DRTS held high after a CTS pulse does not cause a second write in the following cycle (CTS_FF=1 blocks it).
- Read:
  - pop = (read_en_N|E|W|S|L) & !empty.
  - On pop, read_ptr rotates left at the edge.
  - Data_out = mem[read_ptr], combinational from registered pointer.
- Count/flags:
  - count (width clog2(DEPTH+1)): +1 on write only, -1 on pop only, unchanged on both.
  - empty = (count==0); full = (count==DEPTH); both registered-derived, no combinational path from inputs.
- Latency: a flit written at edge t is visible on Data_out with empty=0 after edge t; earliest pop at edge t+1.
- Boundaries:
  - Pointers wrap after DEPTH rotations (bit DEPTH-1 -> bit0).
  - full=1: DRTS is ignored, CTS stays 0, no overwrite.
  - full=1 with pop in a cycle: write still refused that cycle (decision uses registered full); accepted the next cycle.
  - empty=1 with read_en: ignored, pointers and count unchanged.
  - Simultaneous write and pop at 0<count<DEPTH: both occur, count unchanged.
  - More than one read_en high: illegal upstream; treated as a single pop.
  - rst mid-handshake: CTS forced 0 next edge, FIFO emptied; the upstream re-sends the pending flit.

Optional Feature:
- Macro: ROUTER_FIFO_OCCUPANCY_EN.
- Defined:
  - Adds output port occupancy [clog2(DEPTH+1)-1:0] = count.
  - Adds sticky output underflow_err, set when read_en is high while empty=1, or more than one read_en is high; cleared only by rst.
- Undefined: neither port exists; behaviour otherwise identical.

Decomposition:
- noc_pkg holds:
  - FLIT_WIDTH default.
  - FIFO_DEPTH default.
  - Port index enum {PORT_N, PORT_E, PORT_W, PORT_S, PORT_L}.
  - One-hot Xbar_sel encodings shared with the arbiter.
  - Pointer rotate function.
- One sub-module: cts_handshake (CTS_FF register and write_en generation), reusable for other link receivers.
- Storage and pointers stay in router_input_fifo.

Test Plan:
- Reset: rst=1 for 2 cycles -> CTS=0, empty=1, full=0; any read_en has no effect.
- Single flit: DRTS=1, RX=32'hA5A5_0001 at cycle 1 -> CTS=1 for exactly cycle 2, empty=0, Data_out=32'hA5A5_0001; DRTS held to cycle 3 -> no second write.
- Fill to full: 4 handshakes with RX=1,2,3,4 -> full=1; 5th DRTS gives CTS=0 indefinitely; read_en_E pulse -> Data_out 1->2, and CTS for the 5th flit on the following eligible cycle.
- Concurrent: count=2, write 8'h77-padded flit and read_en_S same cycle -> count stays 2, order preserved.
- Wrap: 10 write/read pairs (values 10..19) -> read order 10..19 exactly, pointers wrap twice.
- Mid-op reset: count=3, rst during a CTS cycle -> next cycle empty=1, CTS=0; with the macro defined, occupancy=0 and underflow_err=0.
